// File: rtl/global_variables.sv
`default_nettype none
// ============================================================================
// Package  : global_variables
// Brief    : Machine-wide widths and the result record carried on the CDB.
// Revision : 1.0 - initial release
// ============================================================================
package global_variables;

    localparam int XLEN          = 32;
    localparam int CDB_TAG_WIDTH = 6;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [XLEN-1:0]          address;
        logic [CDB_TAG_WIDTH-1:0] tag;
    } cdb_entry_t;

endpackage
`default_nettype wire

// File: rtl/cdb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cdb_result_buffer
// Brief    : Circular FIFO holding completed FU results until the CDB is won.
//            Define CDB_RESULT_BUFFER_BYPASS_EN for same-cycle empty bypass.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_result_buffer
    import global_variables::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_result,
    input  logic [XLEN-1:0]            in_address,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       get_bus,
    input  logic                       bus_granted,
    output logic                       cdb_valid,
    output logic [XLEN-1:0]            cdb_result,
    output logic [XLEN-1:0]            cdb_address,
    output logic [TAG_WIDTH-1:0]       cdb_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    cdb_entry_t         r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_head_q, w_head_d;
    logic [c_PTR_W-1:0] r_tail_q, w_tail_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_bypass;
    logic       w_wr_en;
    cdb_entry_t w_in_entry;
    cdb_entry_t w_out_entry;

    assign w_empty    = (r_count_q == '0);
    assign w_full     = (r_count_q == c_CNT_W'(DEPTH));
    assign w_in_entry = '{result: in_result, address: in_address, tag: CDB_TAG_WIDTH'(in_tag)};

`ifdef CDB_RESULT_BUFFER_BYPASS_EN
    // A result broadcast straight from the input is never stored.
    assign w_bypass = w_empty && in_valid && bus_granted;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop   = bus_granted && !w_empty;
    assign w_push  = in_valid && !w_full && !w_bypass;
    assign w_wr_en = w_push && !flush;

    always_comb begin
        w_out_entry = '0;
        get_bus     = !w_empty;
        cdb_valid   = w_pop;
        if (!w_empty) begin
            w_out_entry = r_mem_q[r_head_q];
        end
`ifdef CDB_RESULT_BUFFER_BYPASS_EN
        else if (in_valid) begin
            w_out_entry = w_in_entry;
        end
        get_bus   = !w_empty || in_valid;
        cdb_valid = bus_granted && (!w_empty || in_valid);
`endif
    end

    assign in_ready    = !w_full;
    assign full        = w_full;
    assign count       = r_count_q;
    assign cdb_result  = w_out_entry.result;
    assign cdb_address = w_out_entry.address;
    assign cdb_tag     = TAG_WIDTH'(w_out_entry.tag);

    always_comb begin
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        if (flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end else begin
            if (w_push) begin
                w_tail_d = r_tail_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                w_head_d = r_head_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
                2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Payload storage needs no reset: outputs are masked while the count is zero.
    always_ff @(posedge clock) begin
        if (w_wr_en && !reset) begin
            r_mem_q[r_tail_q] <= w_in_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_result_buffer
// Brief    : Directed and random stimulus against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_result_buffer;
    import global_variables::*;

    localparam int DEPTH     = 4;
    localparam int TAG_WIDTH = 6;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [XLEN-1:0]        in_result;
    logic [XLEN-1:0]        in_address;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic                   in_ready;
    logic                   flush;
    logic                   get_bus;
    logic                   bus_granted;
    logic                   cdb_valid;
    logic [XLEN-1:0]        cdb_result;
    logic [XLEN-1:0]        cdb_address;
    logic [TAG_WIDTH-1:0]   cdb_tag;
    logic [$clog2(DEPTH):0] count;
    logic                   full;

    int n_checks = 0;
    int n_errors = 0;

    cdb_entry_t model_q [$];

    cdb_result_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_result   (in_result),
        .in_address  (in_address),
        .in_tag      (in_tag),
        .in_ready    (in_ready),
        .flush       (flush),
        .get_bus     (get_bus),
        .bus_granted (bus_granted),
        .cdb_valid   (cdb_valid),
        .cdb_result  (cdb_result),
        .cdb_address (cdb_address),
        .cdb_tag     (cdb_tag),
        .count       (count),
        .full        (full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_idle();
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_result   = '0;
        in_address  = '0;
        in_tag      = '0;
        flush       = 1'b0;
        bus_granted = 1'b0;
    endtask

    // One clock: drive, compare outputs against the model, clock the edge, update the model.
    task automatic cyc(input logic v, input logic [XLEN-1:0] res, input logic [TAG_WIDTH-1:0] tg,
                       input logic gnt, input logic fl, input logic rs);
        int         sz;
        logic       e_gb, e_cv, byp;
        cdb_entry_t e_out;
        cdb_entry_t ent;
        reset       = rs;
        in_valid    = v;
        in_result   = res;
        in_address  = res ^ 32'hA5A5_0000;
        in_tag      = tg;
        bus_granted = gnt;
        flush       = fl;
        #1;
        ent = '{result: res, address: res ^ 32'hA5A5_0000, tag: CDB_TAG_WIDTH'(tg)};
        sz  = model_q.size();
        byp = 1'b0;
        e_gb  = (sz != 0);
        e_cv  = gnt && (sz != 0);
        e_out = (sz != 0) ? model_q[0] : '0;
`ifdef CDB_RESULT_BUFFER_BYPASS_EN
        if (sz == 0 && v) begin
            e_gb  = 1'b1;
            e_cv  = gnt;
            e_out = ent;
            byp   = gnt;
        end
`endif
        if (!rs) begin
            chk("count",       XLEN'(count), XLEN'(sz));
            chk("full",        XLEN'(full), XLEN'(sz == DEPTH));
            chk("in_ready",    XLEN'(in_ready), XLEN'(sz != DEPTH));
            chk("get_bus",     XLEN'(get_bus), XLEN'(e_gb));
            chk("cdb_valid",   XLEN'(cdb_valid), XLEN'(e_cv));
            chk("cdb_result",  cdb_result, e_out.result);
            chk("cdb_address", cdb_address, e_out.address);
            chk("cdb_tag",     XLEN'(cdb_tag), XLEN'(e_out.tag));
        end
        @(posedge clock);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (gnt && sz != 0) void'(model_q.pop_front());
            if (v && sz < DEPTH && !byp) model_q.push_back(ent);
        end
        @(negedge clock);
        set_idle();
        #1;
    endtask

    task automatic push(input logic [XLEN-1:0] val);
        cyc(1'b1, val, TAG_WIDTH'(val), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic grant();
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        set_idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_count",   XLEN'(count), 0);
        chk("reset_ready",   XLEN'(in_ready), 1);
        chk("reset_get_bus", XLEN'(get_bus), 0);
        chk("reset_result",  cdb_result, 0);

        push(32'h11); push(32'h22); push(32'h33);
        chk("three_count",   XLEN'(count), 3);
        chk("three_get_bus", XLEN'(get_bus), 1);
        chk("three_valid",   XLEN'(cdb_valid), 0);
        chk("three_head",    cdb_result, 32'h11);

        grant(); grant(); grant();
        chk("drain_count",   XLEN'(count), 0);
        chk("drain_get_bus", XLEN'(get_bus), 0);

        for (int i = 0; i < 4; i++) push(32'h100 + i);
        chk("full_after_4", XLEN'(full), 1);
        push(32'h1FF);
        chk("fifth_dropped", XLEN'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("full_drain_order", cdb_result, 32'h100 + i);
            grant();
        end
        chk("full_drain_empty", XLEN'(count), 0);

        push(32'h11); push(32'h22);
        cyc(1'b1, 32'h44, 6'h04, 1'b1, 1'b0, 1'b0);
        chk("simul_count", XLEN'(count), 2);
        chk("simul_head",  cdb_result, 32'h22);
        grant();
        chk("simul_last", cdb_result, 32'h44);
        grant();
        push(32'h200);
        for (int i = 1; i <= 10; i++) cyc(1'b1, 32'h200 + i, TAG_WIDTH'(i), 1'b1, 1'b0, 1'b0);
        chk("wrap_head", cdb_result, 32'h20A);
        grant();

        push(32'h61); push(32'h62); push(32'h63);
        cyc(1'b1, 32'h99, 6'h09, 1'b0, 1'b1, 1'b0);
        chk("flush_count",   XLEN'(count), 0);
        chk("flush_get_bus", XLEN'(get_bus), 0);
        grant();

`ifdef CDB_RESULT_BUFFER_BYPASS_EN
        reset = 1'b0; in_valid = 1'b1; in_result = 32'h55; bus_granted = 1'b1;
        #1;
        chk("bypass_valid",  XLEN'(cdb_valid), 1);
        chk("bypass_result", cdb_result, 32'h55);
        set_idle();
        #1;
`endif
        cyc(1'b1, 32'h55, 6'h15, 1'b1, 1'b0, 1'b0);
`ifdef CDB_RESULT_BUFFER_BYPASS_EN
        chk("bypass_count", XLEN'(count), 0);
`else
        chk("latency_visible", cdb_result, 32'h55);
        grant();
`endif

        push(32'h71); push(32'h72);
        cyc(1'b1, 32'h73, 6'h03, 1'b1, 1'b0, 1'b1);
        chk("midreset_count",   XLEN'(count), 0);
        chk("midreset_get_bus", XLEN'(get_bus), 0);

        for (int i = 0; i < 300; i++) begin
            logic v, g;
            v = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            g = (i < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            cyc(v, $urandom, TAG_WIDTH'($urandom), g,
                $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
